// File: rtl/comparator_pkg.sv
// Shared types and defaults for the registered comparator and its combinational core.
package comparator_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } cmp_res_t;

endpackage : comparator_pkg

// File: rtl/comparator_core.sv
// Purely combinational magnitude comparison of a against b, unsigned or two's complement.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  logic a_lt_b;

  generate
    if (SIGNED) begin : g_signed
      assign a_lt_b = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign a_lt_b = a < b;
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res = EQ;
    if (a != b) begin
      res = a_lt_b ? LT : GT;
    end
  end

endmodule : comparator_core

// File: rtl/comparator.sv
// Registered comparator with one-cycle latency; COMPARATOR_STATS_EN adds saturating
// per-result event counters with a synchronous clear.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit SIGNED    = 1'b0,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef COMPARATOR_STATS_EN
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] cnt_eq,
  output logic [CNT_WIDTH-1:0] cnt_gt,
  output logic [CNT_WIDTH-1:0] cnt_lt,
`endif
  output logic                 out_valid,
  output logic                 equal,
  output logic                 greater,
  output logic                 lower
);

  cmp_res_t res;

  comparator_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a   (a),
    .b   (b),
    .res (res)
  );

  logic out_valid_q, out_valid_d;
  logic equal_q, equal_d;
  logic greater_q, greater_d;
  logic lower_q, lower_d;

  // Flags only move on a valid sample; otherwise they hold the last result.
  always_comb begin
    out_valid_d = in_valid;
    equal_d     = equal_q;
    greater_d   = greater_q;
    lower_d     = lower_q;
    if (in_valid) begin
      equal_d   = (res == EQ);
      greater_d = (res == GT);
      lower_d   = (res == LT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      lower_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
      lower_q     <= lower_d;
    end
  end

  assign out_valid = out_valid_q;
  assign equal     = equal_q;
  assign greater   = greater_q;
  assign lower     = lower_q;

`ifdef COMPARATOR_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_eq_q, cnt_eq_d;
  logic [CNT_WIDTH-1:0] cnt_gt_q, cnt_gt_d;
  logic [CNT_WIDTH-1:0] cnt_lt_q, cnt_lt_d;

  // Clear wins over a coincident increment; counters stick at all-ones.
  always_comb begin
    cnt_eq_d = cnt_eq_q;
    cnt_gt_d = cnt_gt_q;
    cnt_lt_d = cnt_lt_q;
    if (stats_clr) begin
      cnt_eq_d = '0;
      cnt_gt_d = '0;
      cnt_lt_d = '0;
    end else if (in_valid) begin
      unique case (res)
        EQ: if (cnt_eq_q != '1) cnt_eq_d = cnt_eq_q + CNT_WIDTH'(1);
        GT: if (cnt_gt_q != '1) cnt_gt_d = cnt_gt_q + CNT_WIDTH'(1);
        LT: if (cnt_lt_q != '1) cnt_lt_d = cnt_lt_q + CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
      cnt_lt_q <= '0;
    end else begin
      cnt_eq_q <= cnt_eq_d;
      cnt_gt_q <= cnt_gt_d;
      cnt_lt_q <= cnt_lt_d;
    end
  end

  assign cnt_eq = cnt_eq_q;
  assign cnt_gt = cnt_gt_q;
  assign cnt_lt = cnt_lt_q;
`endif

endmodule : comparator

// File: tb/tb_comparator.sv
// Self-checking bench: an unsigned and a signed 4-bit comparator share stimulus; expected
// flags are queued when a valid sample is driven and popped when the result is due.
module tb_comparator;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a, b;
  logic          stats_clr;

  logic          u_ov, u_eq, u_gt, u_lt;
  logic          s_ov, s_eq, s_gt, s_lt;
  logic [CW-1:0] u_cnt_eq, u_cnt_gt, u_cnt_lt;
  logic [15:0]   s_cnt_eq, s_cnt_gt, s_cnt_lt;

  comparator #(.WIDTH(W), .SIGNED(1'b0), .CNT_WIDTH(CW)) u_uns (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef COMPARATOR_STATS_EN
    .stats_clr (stats_clr),
    .cnt_eq    (u_cnt_eq),
    .cnt_gt    (u_cnt_gt),
    .cnt_lt    (u_cnt_lt),
`endif
    .out_valid (u_ov),
    .equal     (u_eq),
    .greater   (u_gt),
    .lower     (u_lt)
  );

  comparator #(.WIDTH(W), .SIGNED(1'b1)) u_sgn (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef COMPARATOR_STATS_EN
    .stats_clr (stats_clr),
    .cnt_eq    (s_cnt_eq),
    .cnt_gt    (s_cnt_gt),
    .cnt_lt    (s_cnt_lt),
`endif
    .out_valid (s_ov),
    .equal     (s_eq),
    .greater   (s_gt),
    .lower     (s_lt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] u;  // {eq, gt, lt} unsigned
    logic [2:0] s;  // {eq, gt, lt} signed
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  last_u, last_s;
  int          m_eq, m_gt, m_lt;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] rel(input int x, input int y);
    return {x == y, x > y, x < y};
  endfunction

  function automatic exp_t make_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   sx, sy;
    sx  = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy  = y[W-1] ? int'(y) - (1 << W) : int'(y);
    e.u = rel(int'(x), int'(y));
    e.s = rel(sx, sy);
    return e;
  endfunction

  function automatic int sat_inc(input int c);
    return (c == (1 << CW) - 1) ? c : c + 1;
  endfunction

  task automatic model_reset();
    sb.delete();
    last_u = 3'b000;
    last_s = 3'b000;
    m_eq = 0; m_gt = 0; m_lt = 0;
  endtask

  // Drive one cycle, then check both instances 1 time unit after the edge.
  task automatic step(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic clr = 1'b0);
    exp_t e;
    in_valid  = v;
    a         = aa;
    b         = bb;
    stats_clr = clr;
    if (v) sb.push_back(make_exp(aa, bb));
    @(posedge clk);
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e      = sb.pop_front();
        last_u = e.u;
        last_s = e.s;
        if (clr) begin
          m_eq = 0; m_gt = 0; m_lt = 0;
        end else if (e.u[2]) m_eq = sat_inc(m_eq);
        else if (e.u[1])     m_gt = sat_inc(m_gt);
        else                 m_lt = sat_inc(m_lt);
      end
    end else if (clr) begin
      m_eq = 0; m_gt = 0; m_lt = 0;
    end
    check("u_out_valid", u_ov, v);
    check("s_out_valid", s_ov, v);
    check("u_flags", {u_eq, u_gt, u_lt}, last_u);
    check("s_flags", {s_eq, s_gt, s_lt}, last_s);
`ifdef COMPARATOR_STATS_EN
    check("cnt_eq", u_cnt_eq, m_eq);
    check("cnt_gt", u_cnt_gt, m_gt);
    check("cnt_lt", u_cnt_lt, m_lt);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; stats_clr = 1'b0;
    model_reset();
    #12;
    check("reset_u", {u_ov, u_eq, u_gt, u_lt}, 4'b0000);
    check("reset_s", {s_ov, s_eq, s_gt, s_lt}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 4'd0, 4'd0);

    // Directed patterns and boundaries.
    step(1'b1, 4'd3,    4'd3);
    step(1'b1, 4'd9,    4'd2);
    step(1'b1, 4'b1001, 4'd2);
    step(1'b1, 4'h0,    4'hF);
    step(1'b1, 4'hF,    4'h0);
    step(1'b1, 4'hF,    4'hF);
    step(1'b1, 4'h0,    4'h0);
    step(1'b1, 4'h7,    4'h8);
    step(1'b1, 4'h8,    4'h7);
    check("dir_signed_7_gt_m8", 64'(make_exp(4'h7, 4'h8).s), 64'(3'b010));

    // Hold: flags keep greater=1 while inputs wander with in_valid low.
    step(1'b1, 4'd5, 4'd1);
    step(1'b0, 4'd2, 4'd9);
    step(1'b0, 4'd0, 4'd15);
    check("hold_greater", u_gt, 1'b1);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 4'(i >> 4), 4'(i));
      check("onehot_u", 64'(u_eq) + 64'(u_gt) + 64'(u_lt), 64'd1);
      check("onehot_s", 64'(s_eq) + 64'(s_gt) + 64'(s_lt), 64'd1);
    end

    // Asynchronous reset between edges while streaming.
    in_valid = 1'b1; a = 4'd7; b = 4'd1;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_u", {u_ov, u_eq, u_gt, u_lt}, 4'b0000);
    check("async_rst_s", {s_ov, s_eq, s_gt, s_lt}, 4'b0000);
    @(posedge clk); #1;
    check("rst_discard", {u_ov, u_eq, u_gt, u_lt}, 4'b0000);
    rst = 1'b0;
    model_reset();
    step(1'b0, 4'd7, 4'd1);
    step(1'b0, 4'd7, 4'd1);
    step(1'b1, 4'd2, 4'd6);
    step(1'b1, 4'd6, 4'd6);

    // Statistics: clear, saturate cnt_eq, then clear alongside a valid sample.
    step(1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 4'd6, 4'd6);
`ifdef COMPARATOR_STATS_EN
    check("cnt_eq_saturated", u_cnt_eq, 64'd15);
`endif
    step(1'b1, 4'd1, 4'd8);
    step(1'b1, 4'd3, 4'd3, 1'b1);
`ifdef COMPARATOR_STATS_EN
    check("clr_priority", {u_cnt_eq, u_cnt_gt, u_cnt_lt}, 12'h000);
`endif
    step(1'b0, 4'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_comparator

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand bit width; legal range is 1 to 64.
REQ-002 Parameter SIGNED, default 0; 0 treats operands as unsigned, 1 treats them as two's complement.
REQ-003 Parameter CNT_WIDTH, default 16, sets the statistics counter width; it applies only when COMPARATOR_STATS_EN is defined.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a and b are sampled on this clock edge.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 out_valid  output  1  one-cycle pulse marking a fresh result.
REQ-010 equal  output  1  registered result of a == b.
REQ-011 greater  output  1  registered result of a > b.
REQ-012 lower  output  1  registered result of a < b.
REQ-013 stats_clr  input  1  synchronous clear of all counters; this port is present only with COMPARATOR_STATS_EN.
REQ-014 cnt_eq, cnt_gt, cnt_lt  output  CNT_WIDTH each  event counters; these ports are present only with COMPARATOR_STATS_EN.

Function
REQ-015 On a clock edge with in_valid=1, the block SHALL register equal, greater and lower from the current a and b.
- Latency is exactly 1 cycle.
- out_valid=1 in the following cycle.
REQ-016 With in_valid=0, the block SHALL hold equal, greater and lower at their last values and drive out_valid=0.
REQ-017 After the first valid sample following reset, exactly one of equal, greater or lower SHALL be 1 at all times.
REQ-018 With SIGNED=1, the block SHALL compare operands as two's complement; the MSB is the sign bit.
REQ-019 Back-to-back in_valid SHALL give one result per cycle with no bubbles; out_valid stays high continuously.
REQ-020 Boundary values SHALL compare correctly:
- all-zeros and all-ones operands;
- most-negative and most-positive values when SIGNED=1.
REQ-021 The comparison SHALL be purely combinational ahead of the output register; no multi-cycle path is allowed.

Reset
REQ-022 While rst=1, the block SHALL asynchronously force out_valid, equal, greater and lower to 0, and all counters to 0.
REQ-023 A valid sample whose edge coincides with rst=1 SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL cancel any pending out_valid; the first result after release appears 1 cycle after the first in_valid.

Configuration
REQ-025 Macro COMPARATOR_STATS_EN defined SHALL include the statistics counters:
- each valid sample increments exactly one of cnt_eq, cnt_gt or cnt_lt, matching the registered flag;
- counters saturate at all-ones and never wrap;
- stats_clr=1 zeroes all three counters on the next edge and takes priority over a simultaneous increment.
REQ-026 Macro COMPARATOR_STATS_EN undefined SHALL remove the stats_clr, cnt_eq, cnt_gt and cnt_lt ports and all counter logic; the comparison function is unchanged.

Structure
REQ-027 Shared package comparator_pkg SHALL hold:
- the result encoding typedef cmp_res_t (EQ, GT, LT) used internally;
- default constants DEF_WIDTH=4 and DEF_CNT_WIDTH=16.
REQ-028 A combinational sub-module comparator_core (WIDTH and SIGNED parameters, output cmp_res_t) SHALL perform the comparison.
- The comparator top holds the registers and the optional counters.

Verification
REQ-029 Exhaustive sweep with WIDTH=4, SIGNED=0, all 256 (a,b) pairs, one per cycle -> each result 1 cycle later matches the reference relation; exactly one flag is high.
REQ-030 a=3, b=3 -> equal=1; a=9, b=2 -> greater=1 (unsigned); SIGNED=1 with a=4'b1001 (-7), b=2 -> lower=1.
REQ-031 Drive a=5, b=1 with in_valid=1, then change a and b with in_valid=0 -> flags hold greater=1; out_valid=1 for one cycle only.
REQ-032 Assert rst asynchronously between edges while results are streaming -> outputs go to 0 immediately; the first post-reset out_valid follows the first in_valid by 1 cycle.
REQ-033 With COMPARATOR_STATS_EN and CNT_WIDTH=4, apply 20 equal samples -> cnt_eq saturates at 15; assert stats_clr together with a valid sample -> all counters read 0.
